// File: rtl/pipelined_mux_n_to_1.sv
// N-to-1 word selector whose output sits behind a two-entry skid buffer, so the
// select point can feed a stallable stage at full rate without a ready->ready path.
module pipelined_mux_n_to_1 #(
  parameter int NBits     = 32,
  parameter int NChannels = 4,
  parameter int SelBits   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Flush,
  input  logic [SelBits-1:0]          Selector,
  input  logic [NChannels*NBits-1:0]  MUX_Data,
  input  logic                        In_Valid,
  output logic                        In_Ready,
  output logic [NBits-1:0]            Out_Data,
  output logic [SelBits-1:0]          Out_Channel,
  output logic                        Out_Valid,
  input  logic                        Out_Ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Out-of-range selectors fall back to channel 0.
  function automatic logic [SelBits-1:0] eff_channel(input logic [SelBits-1:0] sel);
    if (32'(sel) < NChannels) return sel;
    return '0;
  endfunction

  state_t              state;
  logic                in_ready_p1;
  logic                out_valid_p1;
  logic [NBits-1:0]    main_data_p1;
  logic [SelBits-1:0]  main_chan_p1;
  logic [NBits-1:0]    skid_data_p1;
  logic [SelBits-1:0]  skid_chan_p1;

  logic [SelBits-1:0]  sel_chan_p0;
  logic [NBits-1:0]    sel_data_p0;

  // ---- stage p0: channel selection on the input side ----
  always_comb begin
    sel_chan_p0 = eff_channel(Selector);
    sel_data_p0 = MUX_Data[32'(sel_chan_p0)*NBits +: NBits];
  end

  // ---- stage p1: main/skid registers and handshake state ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= EMPTY;
      in_ready_p1  <= 1'b1;
      out_valid_p1 <= 1'b0;
      main_data_p1 <= '0;
      main_chan_p1 <= '0;
      skid_data_p1 <= '0;
      skid_chan_p1 <= '0;
    end else if (Flush) begin
      state        <= EMPTY;
      in_ready_p1  <= 1'b1;
      out_valid_p1 <= 1'b0;
      main_data_p1 <= '0;
      main_chan_p1 <= '0;
      skid_data_p1 <= '0;
      skid_chan_p1 <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (In_Valid) begin
            main_data_p1 <= sel_data_p0;
            main_chan_p1 <= sel_chan_p0;
            state        <= ONE;
            out_valid_p1 <= 1'b1;
          end
        end
        ONE: begin
          if (In_Valid && Out_Ready) begin
            main_data_p1 <= sel_data_p0;
            main_chan_p1 <= sel_chan_p0;
          end else if (In_Valid) begin
            skid_data_p1 <= sel_data_p0;
            skid_chan_p1 <= sel_chan_p0;
            state        <= FULL;
            in_ready_p1  <= 1'b0;
          end else if (Out_Ready) begin
            state        <= EMPTY;
            out_valid_p1 <= 1'b0;
          end
        end
        FULL: begin
          // Input is ignored here; the head drains and the skid word moves up.
          if (Out_Ready) begin
            main_data_p1 <= skid_data_p1;
            main_chan_p1 <= skid_chan_p1;
            state        <= ONE;
            in_ready_p1  <= 1'b1;
          end
        end
        default: begin
          state        <= EMPTY;
          in_ready_p1  <= 1'b1;
          out_valid_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign In_Ready    = in_ready_p1;
  assign Out_Valid   = out_valid_p1;
  assign Out_Data    = main_data_p1;
  assign Out_Channel = main_chan_p1;

endmodule

// File: doc/pipelined_mux_n_to_1.md
# pipelined_mux_n_to_1

Parametrised N-to-1 datapath selector with a registered, flow-controlled output. It takes a selector and NChannels candidate words, captures the chosen word on an input valid/ready handshake, and presents it through a two-entry skid buffer on an output valid/ready handshake. It replaces fixed combinational 3:1 selectors wherever a pipeline stage boundary must sit directly after the select point, such as write-back or forwarding selection feeding a stallable stage. Full throughput is one word per cycle with no combinational path from Out_Ready to In_Ready.

## Interface
- NBits, 32, width of each data channel.
- NChannels, 4, number of input channels; must be ≥ 2.
- SelBits, 2, selector width; must satisfy 2^SelBits ≥ NChannels.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Flush  input  1  synchronous pipeline flush.
- Selector  input  SelBits  channel index, sampled when the input handshake fires.
- MUX_Data  input  NChannels*NBits  flattened channels; channel i occupies bits [i*NBits +: NBits].
- In_Valid  input  1  Selector and MUX_Data are valid this cycle.
- In_Ready  output  1  block can accept input this cycle.
- Out_Data  output  NBits  selected word at the head of the buffer.
- Out_Channel  output  SelBits  effective channel index of Out_Data.
- Out_Valid  output  1  Out_Data and Out_Channel are valid.
- Out_Ready  input  1  downstream accepts Out_Data this cycle.

## Operation
- Effective channel: Selector if Selector < NChannels, else 0. Out-of-range selectors choose channel 0, which generalises the existing default-to-Data0 rule.
- Accept: In_Valid & In_Ready. Fire: Out_Valid & Out_Ready.
- Storage: a main register and a skid register, each holding {data, channel}. Out_Data and Out_Channel always drive the main register.
- State machine (2-bit state register):
  - EMPTY: In_Ready=1, Out_Valid=0. On accept, load main and go to ONE.
  - ONE: In_Ready=1, Out_Valid=1.
    - accept & fire: load main with the new word; stay in ONE.
    - accept & !fire: load skid with the new word; go to FULL.
    - !accept & fire: go to EMPTY.
    - neither: hold.
  - FULL: In_Ready=0, Out_Valid=1. On fire, copy skid to main and go to ONE. In_Valid is ignored.
- In_Ready and Out_Valid are decoded only from the state register. Neither depends combinationally on In_Valid or Out_Ready.
- Flush has the highest synchronous priority:
  - next state is EMPTY;
  - main and skid are cleared to 0;
  - any accept or fire in the same cycle is discarded. Upstream sees In_Ready=1 that cycle, but the word is dropped by design.
- Reset (asynchronous, reset=0):
  - state goes to EMPTY;
  - main and skid are cleared;
  - outputs during and after reset: Out_Valid=0, Out_Data=0, Out_Channel=0, In_Ready=1.
- Reset mid-operation discards all buffered words immediately, without waiting for a clock edge.
- Word order is strictly preserved; no word is dropped or duplicated except by Flush or reset.

## Timing
- Latency: 1 cycle. A word accepted at edge k is visible on Out_Data with Out_Valid=1 after edge k.
- Throughput: 1 word per cycle while Out_Ready=1 continuously.
- Back-pressure: Out_Ready may drop at any cycle. At most one further word is absorbed (into skid), and In_Ready falls after that edge.
- Recovery: on the first fire in FULL, In_Ready returns to 1 after that edge. No bubble is inserted on the output.
- Out_Data and Out_Channel stay stable while Out_Valid=1 and Out_Ready=0.

## Test plan
- Reset and selection:
  - Stimulus: assert reset mid-stream, release, then NChannels=4, NBits=32, channels 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444, sending Selector 0..3 on consecutive cycles with Out_Ready=1.
  - Required: during reset Out_Valid=0, Out_Data=0, In_Ready=1. Afterwards, on the cycles after each accept, Out_Data steps through 0x11111111..0x44444444 and Out_Channel through 0..3.
- Out-of-range selector:
  - Stimulus: NChannels=3, SelBits=2, Selector=3, channel 0 = 0xDEADBEEF.
  - Required: Out_Data=0xDEADBEEF, Out_Channel=0.
- Back-pressure:
  - Stimulus: stream words A, B, C with In_Valid=1, dropping Out_Ready to 0 after A is presented.
  - Required: B is held in skid; In_Ready=0 the next cycle; C is not accepted; Out_Data stays A.
  - Then raise Out_Ready. Required: outputs are A, then B, then C in order, with no gap and no loss.
- Simultaneous accept and fire in ONE:
  - Stimulus: hold In_Valid=1 and Out_Ready=1 for 16 cycles with an incrementing data pattern.
  - Required: 16 consecutive outputs, one per cycle; state never reaches FULL.
- Flush:
  - Stimulus: assert Flush in FULL while In_Valid=1 and Out_Ready=1.
  - Required: next cycle Out_Valid=0, Out_Data=0, In_Ready=1; the input word from the flush cycle never appears on the output.
- Random regression: randomised In_Valid, Out_Ready and Selector for 10k cycles. Required: the output sequence matches a scoreboard queue exactly, and In_Ready never depends combinationally on Out_Ready.
